parallel_frame_receiver: RTL and testbench
==========================================

Name: parallel_frame_receiver

Overview:
- Receive-side counterpart of the Doppler board's 8-bit parallel data-out port. Captures bytes strobed by an external data clock while the frame flag is high, and rebuilds 16-bit samples from byte pairs.
- Buffers the samples in a small FIFO and delivers them over a valid/ready stream.
- Reports end of frame and frame-length, parity and overflow errors.
- Sits in the host-side/capture FPGA, or in loopback test builds driven by the data-out port.

Parameters:
- FIFO_DEPTH, 16, number of 16-bit entries in the output FIFO (power of two, ≥4).
- SYNC_STAGES, 2, synchronizer flops on DATA_CLK_IN, FLAG_FRAME_IN and DATA_IN.

Ports:
- CLK  input  1  system clock (64 MHz); must be ≥4× DATA_CLK_IN frequency.
- RESET  input  1  asynchronous, active-low reset.
- ENABLE  input  1  receiver enable; low forces IDLE and flushes the FIFO.
- FRAME_LENGTH  input  16  expected bytes per frame; sampled at frame start.
- DATA_CLK_IN  input  1  external byte strobe; data is valid at its rising edge.
- FLAG_FRAME_IN  input  1  external frame flag; high for the duration of a frame.
- DATA_IN  input  8  external byte.
- WORD_OUT  output  16  assembled sample.
- WORD_VALID  output  1  WORD_OUT valid.
- WORD_READY  input  1  consumer accepts the word when VALID&READY at a CLK rising edge.
- WORD_LAST  output  1  qualifies WORD_OUT as the final word of a frame.
- FRAME_DONE  output  1  one-cycle pulse at frame end.
- FRAME_ERR  output  1  one-cycle pulse with FRAME_DONE when the byte count ≠ latched length or the count is odd.
- OVERFLOW  output  1  sticky; set when a word is dropped because the FIFO is full.
- BYTE_COUNT  output  16  bytes accepted in the current or last frame.

Behaviour:
- Reset (RESET=0): all outputs 0, state IDLE, FIFO empty, synchronizers cleared.
- Input path: the three inputs pass through SYNC_STAGES flops on CLK. A byte event is a 0→1 transition of the synchronized DATA_CLK_IN. The byte captured is the synchronized DATA_IN in the same cycle as the event.
- The flag is edge-detected from its synchronized copy.
- State machine:
  - IDLE: entered on reset or ENABLE=0. Goes to ARM when ENABLE=1.
  - ARM: waits for synchronized flag = 0, which prevents joining a frame mid-way. Then goes to WAIT.
  - WAIT: on flag 0→1, latches FRAME_LENGTH, clears BYTE_COUNT and the byte phase, goes to FRAME.
  - FRAME: each byte event with flag high increments BYTE_COUNT (saturates at 0xFFFF).
    - Even phase: byte → high-byte register.
    - Odd phase: word = {high, byte} pushed to FIFO; WORD_LAST=1 if BYTE_COUNT after increment == latched length.
    - Bytes beyond the latched length are counted but not pushed.
    - Flag 1→0 goes to DONE.
    - A byte event and a flag fall in the same cycle: the byte is dropped, not counted.
  - DONE: one cycle. FRAME_DONE=1; FRAME_ERR=1 if BYTE_COUNT ≠ latched length or BYTE_COUNT is odd. A dangling high byte is discarded. Then goes to WAIT.
- Latched length 0: no words are pushed; any byte gives FRAME_ERR.
- FIFO: push-to-WORD_VALID latency is 1 CLK from the odd-byte event. WORD_OUT/WORD_LAST are held stable while VALID&!READY.
- Simultaneous push and pop when full is allowed (no overflow).
- Push when full and no pop: word dropped, OVERFLOW set. OVERFLOW clears only on reset or ENABLE=0.
- Pointers wrap modulo FIFO_DEPTH; a separate count distinguishes full from empty.
- ENABLE falling mid-frame: next cycle IDLE, FIFO flushed, WORD_VALID=0, no FRAME_DONE. BYTE_COUNT retains its value.
- RESET asserted mid-frame: immediate return to the reset values above.

Test Plan:
- FRAME_LENGTH=8; frame of bytes 0x12,0x34,0x56,0x78,0x9A,0xBC,0xDE,0xF0; DATA_CLK_IN=8 MHz; READY=1 → words 0x1234, 0x5678, 0x9ABC, 0xDEF0; LAST only on 0xDEF0; FRAME_DONE one pulse; FRAME_ERR=0; BYTE_COUNT=8.
- FRAME_LENGTH=8 with a 7-byte frame → 3 words, none with LAST; FRAME_DONE and FRAME_ERR both pulse; BYTE_COUNT=7. Next correct frame has no error.
- FRAME_LENGTH=4 with a 6-byte frame → 2 words, LAST on the second; the third pair is not pushed; FRAME_ERR pulses; BYTE_COUNT=6.
- FIFO_DEPTH=4, READY=0, FRAME_LENGTH=12 → 4 words held with the first stable; OVERFLOW=1 after the 5th word. Raising READY drains exactly 4 words in order.
- Enable with flag already high mid-frame → no words until the flag falls and rises again; the next frame is received intact.
- ENABLE→0 after 3 bytes, then →1 → WORD_VALID=0 and no FRAME_DONE. The next full 4096-byte frame yields 2048 words with LAST on word 2048.

Source files
------------

// File: rtl/parallel_frame_receiver_if.sv
// Output sample stream of the parallel frame receiver.
//   word        : assembled 16-bit sample
//   word_valid  : word/word_last hold a sample
//   word_ready  : consumer accepts the sample on a clock edge with word_valid high
//   word_last   : sample is the final word of its frame
// The receiver connects through the master modport and the consumer through the slave modport.
interface parallel_frame_receiver_if;
  logic [15:0] word;
  logic        word_valid;
  logic        word_ready;
  logic        word_last;

  modport master (output word, output word_valid, output word_last, input word_ready);
  modport slave  (input word, input word_valid, input word_last, output word_ready);
endinterface

// File: rtl/parallel_frame_receiver.sv
// Receive side of an 8-bit parallel data-out port. Bytes strobed by an external
// data clock while the frame flag is high are paired into 16-bit samples, buffered
// in a small FIFO and delivered over a valid/ready stream.
// Ports:
//   clk_i            system clock, at least 4x the external data clock
//   rst_ni           asynchronous active-low reset
//   enable_i         receiver enable; low forces IDLE and flushes the FIFO
//   frame_length_i   expected bytes per frame, latched at frame start
//   data_clk_i       external byte strobe (byte valid at its rising edge)
//   flag_frame_i     external frame flag
//   data_i           external byte
//   word_if          output sample stream (master side)
//   frame_done_o     one-cycle pulse at frame end
//   frame_err_o      pulse with frame_done_o on length mismatch or odd byte count
//   overflow_o       sticky: a word was dropped because the FIFO was full
//   byte_count_o     bytes accepted in the current or last frame
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | disabled / after reset
// S_ARM   | enabled, waiting for the flag to be low (no mid-frame join)
// S_WAIT  | waiting for the flag rising edge
// S_FRAME | collecting bytes and pushing words
// S_DONE  | one cycle: report frame end and error status
module parallel_frame_receiver #(
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      enable_i,
  input  logic [15:0]               frame_length_i,
  input  logic                      data_clk_i,
  input  logic                      flag_frame_i,
  input  logic [7:0]                data_i,
  parallel_frame_receiver_if.master word_if,
  output logic                      frame_done_o,
  output logic                      frame_err_o,
  output logic                      overflow_o,
  output logic [15:0]               byte_count_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT,
    S_FRAME,
    S_DONE
  } state_t;

  // synchronizer chain, bit 9 = data clock, bit 8 = flag, bits 7:0 = data
  logic [9:0] sync_q [SYNC_STAGES];
  logic       dclk_prev_q;
  logic       flag_prev_q;

  logic       dclk_s;
  logic       flag_s;
  logic [7:0] data_s;
  logic       byte_evt;
  logic       flag_rise;
  logic       flag_fall;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      dclk_prev_q <= 1'b0;
      flag_prev_q <= 1'b0;
    end else begin
      sync_q[0] <= {data_clk_i, flag_frame_i, data_i};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      dclk_prev_q <= dclk_s;
      flag_prev_q <= flag_s;
    end
  end

  assign dclk_s    = sync_q[SYNC_STAGES-1][9];
  assign flag_s    = sync_q[SYNC_STAGES-1][8];
  assign data_s    = sync_q[SYNC_STAGES-1][7:0];
  assign byte_evt  = dclk_s & ~dclk_prev_q;
  assign flag_rise = flag_s & ~flag_prev_q;
  assign flag_fall = ~flag_s & flag_prev_q;

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] cnt_q, cnt_d;
  logic        phase_q, phase_d;
  logic [7:0]  hi_q, hi_d;
  logic        push;
  logic [16:0] push_entry;
  logic [15:0] cnt_inc;

  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      hi_q    <= hi_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    phase_d    = phase_q;
    hi_d       = hi_q;
    push       = 1'b0;
    push_entry = '0;
    if (!enable_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_ARM;
        S_ARM: begin
          if (!flag_s) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (flag_rise) begin
            len_d   = frame_length_i;
            cnt_d   = '0;
            phase_d = 1'b0;
            state_d = S_FRAME;
          end
        end
        S_FRAME: begin
          // a byte coinciding with the flag fall is dropped
          if (flag_fall) begin
            state_d = S_DONE;
          end else if (byte_evt && flag_s) begin
            cnt_d   = cnt_inc;
            phase_d = ~phase_q;
            if (!phase_q) begin
              hi_d = data_s;
            end else if (cnt_inc <= len_q) begin
              push       = 1'b1;
              push_entry = {(cnt_inc == len_q), hi_q, data_s};
            end
          end
        end
        S_DONE: begin
          phase_d = 1'b0;
          state_d = S_WAIT;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign frame_done_o = (state_q == S_DONE);
  assign frame_err_o  = (state_q == S_DONE) && ((cnt_q != len_q) || cnt_q[0]);
  assign byte_count_o = cnt_q;

  // output FIFO; entry = {last, word}
  logic [16:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] fcnt_q;
  logic          ovf_q;
  logic          full;
  logic          valid;
  logic          pop;
  logic          do_push;

  assign full    = (fcnt_q == FULL_COUNT);
  assign valid   = (fcnt_q != '0);
  assign pop     = valid & word_if.word_ready;
  // when full, a push is only accepted if a pop frees the slot in the same cycle
  assign do_push = push & (~full | pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
      ovf_q    <= 1'b0;
    end else if (!enable_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      fcnt_q <= fcnt_q + CW'(do_push) - CW'(pop);
      if (push && full && !pop) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_entry;
  end

  assign word_if.word_valid = valid;
  assign word_if.word       = valid ? mem_q[rd_ptr_q][15:0] : 16'h0000;
  assign word_if.word_last  = valid ? mem_q[rd_ptr_q][16] : 1'b0;
  assign overflow_o         = ovf_q;

endmodule

// File: tb/tb_parallel_frame_receiver.sv
module tb_parallel_frame_receiver;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] frame_length = '0;
  logic        dclk = 1'b0;
  logic        flag = 1'b0;
  logic [7:0]  data = '0;
  logic        frame_done, frame_err, overflow;
  logic [15:0] byte_count;

  parallel_frame_receiver_if wif();

  parallel_frame_receiver #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .frame_length_i(frame_length),
    .data_clk_i(dclk), .flag_frame_i(flag), .data_i(data), .word_if(wif.master),
    .frame_done_o(frame_done), .frame_err_o(frame_err), .overflow_o(overflow),
    .byte_count_o(byte_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0]  tx[$];
  logic [16:0] exp_q[$];
  logic [16:0] got_q[$];
  logic        exp_err;
  int done_cnt = 0, err_cnt = 0, err_orphan = 0, stall_viol = 0;
  logic        prev_stall = 1'b0;
  logic [16:0] prev_word = '0;
  logic        rand_ready = 1'b0;

  // stream and pulse monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (wif.word_valid && wif.word_ready) got_q.push_back({wif.word_last, wif.word});
      if (frame_done) done_cnt++;
      if (frame_err) err_cnt++;
      if (frame_err && !frame_done) err_orphan++;
      if (prev_stall && (wif.word_valid !== 1'b1 || {wif.word_last, wif.word} !== prev_word))
        stall_viol++;
      prev_stall = wif.word_valid && !wif.word_ready;
      prev_word  = {wif.word_last, wif.word};
    end else begin
      prev_stall = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1 wif.word_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame_begin(input logic [15:0] len);
    tx.delete();
    got_q.delete();
    frame_length = len;
    wait_clks(2);
    flag = 1'b1;
    wait_clks(4);
  endtask

  task automatic send_byte(input logic [7:0] b);
    data = b;
    wait_clks(4);
    dclk = 1'b1;
    wait_clks(4);
    dclk = 1'b0;
    tx.push_back(b);
  endtask

  task automatic send_random(input int n);
    for (int i = 0; i < n; i++) send_byte(8'($urandom));
  endtask

  task automatic frame_end();
    wait_clks(4);
    flag = 1'b0;
    wait_clks(10);
  endtask

  // reference: byte pairs form words; a pair is delivered only while the running
  // byte count stays within the expected length, and flagged last when it hits it
  function automatic void build_expect(input int len);
    int n;
    n = tx.size();
    exp_q.delete();
    for (int k = 0; 2 * k + 1 < n; k++) begin
      if (2 * k + 2 <= len)
        exp_q.push_back({(2 * k + 2 == len), tx[2*k], tx[2*k+1]});
    end
    exp_err = (n != len) || (n % 2 != 0);
  endfunction

  task automatic test_reset();
    checks++;
    if ({wif.word_valid, wif.word_last, frame_done, frame_err, overflow} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got %b required 00000",
               {wif.word_valid, wif.word_last, frame_done, frame_err, overflow});
    end
    checks++;
    if (wif.word !== 16'h0 || byte_count !== 16'h0) begin
      errors++;
      $display("FAIL reset_values word=%h count=%h required 0", wif.word, byte_count);
    end
  endtask

  task automatic test_nominal();
    int d0, e0;
    logic [7:0] bytes [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    d0 = done_cnt; e0 = err_cnt;
    frame_begin(16'd8);
    foreach (bytes[i]) send_byte(bytes[i]);
    frame_end();
    build_expect(8);
    checks++;
    if (got_q.size() != 4) begin
      errors++; $display("FAIL nominal_count got %0d required 4", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL nominal_word[%0d] got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (done_cnt - d0 != 1 || err_cnt - e0 != 0) begin
      errors++; $display("FAIL nominal_pulses done=%0d err=%0d required 1 0", done_cnt - d0, err_cnt - e0);
    end
    checks++;
    if (byte_count !== 16'd8) begin
      errors++; $display("FAIL nominal_byte_count got %0d required 8", byte_count);
    end
  endtask

  task automatic test_lengths();
    int lens [4] = '{8, 8, 4, 0};
    int ns   [4] = '{7, 8, 6, 3};
    for (int t = 0; t < 4; t++) begin
      int d0, e0;
      d0 = done_cnt; e0 = err_cnt;
      frame_begin(16'(lens[t]));
      send_random(ns[t]);
      frame_end();
      build_expect(lens[t]);
      checks++;
      if (got_q.size() != exp_q.size()) begin
        errors++; $display("FAIL len%0d_count got %0d required %0d", t, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL len%0d_word[%0d] got %h required %h", t, i, got_q[i], exp_q[i]);
        end
      end
      checks++;
      if (done_cnt - d0 != 1 || (err_cnt - e0) != int'(exp_err)) begin
        errors++; $display("FAIL len%0d_pulses done=%0d err=%0d required 1 %0d",
                           t, done_cnt - d0, err_cnt - e0, exp_err);
      end
      checks++;
      if (byte_count !== 16'(ns[t])) begin
        errors++; $display("FAIL len%0d_byte_count got %0d required %0d", t, byte_count, ns[t]);
      end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      int len, n, d0, e0;
      len = $urandom_range(0, 10);
      n = ($urandom_range(0, 1) == 1) ? len : int'($urandom_range(0, 10));
      d0 = done_cnt; e0 = err_cnt;
      frame_begin(16'(len));
      rand_ready = 1'b1;
      send_random(n);
      frame_end();
      rand_ready = 1'b0;
      wait_clks(1);
      wif.word_ready = 1'b1;
      wait_clks(DEPTH + 4);
      build_expect(len);
      checks++;
      if (got_q.size() != exp_q.size()) begin
        errors++; $display("FAIL rand%0d_count got %0d required %0d", t, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL rand%0d_word[%0d] got %h required %h", t, i, got_q[i], exp_q[i]);
        end
      end
      checks++;
      if (done_cnt - d0 != 1 || (err_cnt - e0) != int'(exp_err) || byte_count !== 16'(n)) begin
        errors++; $display("FAIL rand%0d_status done=%0d err=%0d count=%0d required 1 %0d %0d",
                           t, done_cnt - d0, err_cnt - e0, byte_count, exp_err, n);
      end
    end
    checks++;
    if (stall_viol != 0 || err_orphan != 0) begin
      errors++; $display("FAIL rand_stall_stable violations=%0d orphan_err=%0d required 0 0", stall_viol, err_orphan);
    end
  endtask

  task automatic test_overflow();
    int d0;
    d0 = done_cnt;
    wif.word_ready = 1'b0;
    frame_begin(16'd12);
    send_random(8);
    wait_clks(3);
    checks++;
    if (wif.word_valid !== 1'b1 || wif.word !== {tx[0], tx[1]} || overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_hold valid=%b word=%h ovf=%b required 1 %h 0",
                         wif.word_valid, wif.word, overflow, {tx[0], tx[1]});
    end
    send_random(2);
    wait_clks(3);
    checks++;
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_set got %b required 1", overflow);
    end
    send_random(2);
    frame_end();
    checks++;
    if (stall_viol != 0 || got_q.size() != 0) begin
      errors++; $display("FAIL ovf_stall violations=%0d popped=%0d required 0 0", stall_viol, got_q.size());
    end
    wif.word_ready = 1'b1;
    wait_clks(DEPTH + 4);
    build_expect(12);
    checks++;
    if (got_q.size() != DEPTH) begin
      errors++; $display("FAIL ovf_drain_count got %0d required %0d", got_q.size(), DEPTH);
    end
    for (int i = 0; i < got_q.size() && i < DEPTH; i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL ovf_word[%0d] got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (overflow !== 1'b1 || done_cnt - d0 != 1) begin
      errors++; $display("FAIL ovf_sticky ovf=%b done=%0d required 1 1", overflow, done_cnt - d0);
    end
    enable = 1'b0;
    wait_clks(2);
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_clear got %b required 0", overflow);
    end
    enable = 1'b1;
    wait_clks(4);
  endtask

  task automatic test_join_midframe();
    int d0, e0;
    d0 = done_cnt;
    enable = 1'b0;
    frame_begin(16'd6);
    send_random(2);
    enable = 1'b1;
    send_random(4);
    frame_end();
    checks++;
    if (got_q.size() != 0 || done_cnt - d0 != 0) begin
      errors++; $display("FAIL join_ignored words=%0d done=%0d required 0 0", got_q.size(), done_cnt - d0);
    end
    d0 = done_cnt; e0 = err_cnt;
    frame_begin(16'd6);
    send_random(6);
    frame_end();
    build_expect(6);
    checks++;
    if (got_q.size() != 3) begin
      errors++; $display("FAIL join_next_count got %0d required 3", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL join_word[%0d] got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (done_cnt - d0 != 1 || err_cnt - e0 != 0) begin
      errors++; $display("FAIL join_pulses done=%0d err=%0d required 1 0", done_cnt - d0, err_cnt - e0);
    end
  endtask

  task automatic test_enable_drop();
    int d0, e0, last_cnt;
    d0 = done_cnt;
    frame_begin(16'd4096);
    send_random(3);
    wait_clks(2);
    enable = 1'b0;
    wait_clks(3);
    checks++;
    if (wif.word_valid !== 1'b0 || byte_count !== 16'd3) begin
      errors++; $display("FAIL drop_state valid=%b count=%0d required 0 3", wif.word_valid, byte_count);
    end
    checks++;
    if (got_q.size() != 1 || (got_q.size() == 1 && got_q[0] !== {1'b0, tx[0], tx[1]})) begin
      errors++; $display("FAIL drop_first_word words=%0d required 1 of %h", got_q.size(), {1'b0, tx[0], tx[1]});
    end
    enable = 1'b1;
    wait_clks(3);
    flag = 1'b0;
    wait_clks(10);
    checks++;
    if (done_cnt - d0 != 0) begin
      errors++; $display("FAIL drop_no_done got %0d required 0", done_cnt - d0);
    end
    d0 = done_cnt; e0 = err_cnt;
    frame_begin(16'd4096);
    send_random(4096);
    frame_end();
    build_expect(4096);
    checks++;
    if (got_q.size() != 2048) begin
      errors++; $display("FAIL big_count got %0d required 2048", got_q.size());
    end
    last_cnt = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      if (got_q[i][16]) last_cnt++;
      if (got_q[i] !== exp_q[i]) begin
        checks++; errors++;
        $display("FAIL big_word[%0d] got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (last_cnt != 1 || got_q.size() == 0 || got_q[got_q.size()-1][16] !== 1'b1) begin
      errors++; $display("FAIL big_last count=%0d required 1 on final word", last_cnt);
    end
    checks++;
    if (done_cnt - d0 != 1 || err_cnt - e0 != 0 || byte_count !== 16'd4096) begin
      errors++; $display("FAIL big_status done=%0d err=%0d count=%0d required 1 0 4096",
                         done_cnt - d0, err_cnt - e0, byte_count);
    end
  endtask

  task automatic test_reset_midframe();
    frame_begin(16'd8);
    send_random(3);
    rst_n = 1'b0;
    #1;
    checks++;
    if (byte_count !== 16'h0 || wif.word_valid !== 1'b0 || overflow !== 1'b0) begin
      errors++; $display("FAIL reset_mid count=%0d valid=%b ovf=%b required 0 0 0",
                         byte_count, wif.word_valid, overflow);
    end
    wait_clks(2);
    rst_n = 1'b1;
    frame_end();
  endtask

  initial begin
    wif.word_ready = 1'b0;
    wait_clks(3);
    test_reset();
    rst_n = 1'b1;
    enable = 1'b1;
    wif.word_ready = 1'b1;
    wait_clks(4);
    test_nominal();
    test_lengths();
    test_random();
    test_overflow();
    test_join_midframe();
    test_enable_drop();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
